alu_issue_ctrl: RTL

Multicycle issue controller that drives the team's 16-bit ALU: the block that produces the ALU's opcode, operand and carry-in inputs and consumes its result. It accepts 4-bit-opcode register-register instructions over a valid/ready handshake, reads operands from an internal 8×16 register file and maps the opcode to the 5-bit ALU op code plus C0. It waits a fixed ALU latency, then writes the ALU output back and reports it.

---
 rtl/alu_issue_pkg.sv | 55 +++++
 rtl/alu_issue_decode.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// instruction opcodes, ALU op codes and instruction field positions.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    // Source of the ALU carry-in for a decoded instruction
    typedef enum logic [1:0] {
        C0_ZERO,
        C0_ONE,
        C0_RS_MSB
    } c0_sel_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_NEG  = 4'h4;
    localparam logic [3:0] OP_CLR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_SET1 = 4'hB;
    localparam logic [3:0] OP_SRL  = 4'hC;
    localparam logic [3:0] OP_SLL  = 4'hD;
    localparam logic [3:0] OP_ASR  = 4'hE;

    localparam logic [4:0] OC_ADD  = 5'b10100;
    localparam logic [4:0] OC_INC  = 5'b10000;
    localparam logic [4:0] OC_SUB  = 5'b10110;
    localparam logic [4:0] OC_DEC  = 5'b10010;
    localparam logic [4:0] OC_NEG  = 5'b10001;
    localparam logic [4:0] OC_CLR  = 5'b00000;
    localparam logic [4:0] OC_MOV  = 5'b01010;
    localparam logic [4:0] OC_NOT  = 5'b00101;
    localparam logic [4:0] OC_AND  = 5'b01000;
    localparam logic [4:0] OC_OR   = 5'b01110;
    localparam logic [4:0] OC_XOR  = 5'b00110;
    localparam logic [4:0] OC_SET1 = 5'b01111;
    localparam logic [4:0] OC_SRL  = 5'b11001;
    localparam logic [4:0] OC_SLL  = 5'b11000;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 9;
    localparam int RS_LSB = 6;
    localparam int RT_LSB = 3;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode decoder: 4-bit instruction opcode to ALU op code,
// carry-in source and illegal-opcode flag.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [3:0] op,
    output logic [4:0] oc,
    output c0_sel_t    c0_sel,
    output logic       illegal
);

    always_comb begin
        oc      = OC_CLR;
        c0_sel  = C0_ZERO;
        illegal = 1'b0;
        case (op)
            OP_ADD:  oc = OC_ADD;
            OP_INC:  begin oc = OC_INC; c0_sel = C0_ONE; end
            OP_SUB:  begin oc = OC_SUB; c0_sel = C0_ONE; end
            OP_DEC:  oc = OC_DEC;
            OP_NEG:  begin oc = OC_NEG; c0_sel = C0_ONE; end
            OP_CLR:  oc = OC_CLR;
            OP_MOV:  oc = OC_MOV;
            OP_NOT:  oc = OC_NOT;
            OP_AND:  oc = OC_AND;
            OP_OR:   oc = OC_OR;
            OP_XOR:  oc = OC_XOR;
            OP_SET1: oc = OC_SET1;
            OP_SRL:  oc = OC_SRL;
            OP_SLL:  oc = OC_SLL;
            // ASR is a right shift whose fill bit is the operand sign
            OP_ASR:  begin oc = OC_SRL; c0_sel = C0_RS_MSB; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue controller for the 16-bit ALU: register file, EXEC latency
// counter and IDLE/DECODE/EXEC/WB FSM. Define ZERO_REG_EN to hard-wire r0 to 0.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic [4:0]  OC,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        C0,
    input  logic [15:0] O,
    output logic        res_valid,
    output logic [2:0]  res_addr,
    output logic [15:0] res_data,
    output logic        err
);

    localparam logic [3:0] EXEC_LAST = 4'(ALU_LAT - 1);

    state_t      state;
    logic [15:0] rf [8];
    logic [3:0]  op_q;
    logic [2:0]  rd_q;
    logic [2:0]  rs_q;
    logic [2:0]  rt_q;
    logic [3:0]  cnt;
    logic        illegal_q;

    logic [4:0]  dec_oc;
    c0_sel_t     dec_c0_sel;
    logic        dec_illegal;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic        c0_val;
    logic        ld_ok;
    logic        wb_ok;

    logic unused_bits;
    assign unused_bits = ^instr[2:0];

    alu_issue_decode u_decode (
        .op      (op_q),
        .oc      (dec_oc),
        .c0_sel  (dec_c0_sel),
        .illegal (dec_illegal)
    );

`ifdef ZERO_REG_EN
    assign ld_ok = (ld_addr != 3'd0);
    assign wb_ok = (rd_q != 3'd0);
`else
    assign ld_ok = 1'b1;
    assign wb_ok = 1'b1;
`endif

    always_comb begin
        rs_val = rf[rs_q];
        rt_val = rf[rt_q];
`ifdef ZERO_REG_EN
        if (rs_q == 3'd0) rs_val = '0;
        if (rt_q == 3'd0) rt_val = '0;
`endif
    end

    always_comb begin
        case (dec_c0_sel)
            C0_ONE:    c0_val = 1'b1;
            C0_RS_MSB: c0_val = rs_val[15];
            default:   c0_val = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            cnt         <= '0;
            illegal_q   <= 1'b0;
            instr_ready <= 1'b1;
            OC          <= '0;
            A           <= '0;
            B           <= '0;
            C0          <= 1'b0;
            res_valid   <= 1'b0;
            res_addr    <= '0;
            res_data    <= '0;
            err         <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The load commits on the accept edge, so DECODE sees it
                    if (ld_en && ld_ok) rf[ld_addr] <= ld_data;
                    if (instr_valid) begin
                        op_q        <= instr[OP_LSB +: 4];
                        rd_q        <= instr[RD_LSB +: 3];
                        rs_q        <= instr[RS_LSB +: 3];
                        rt_q        <= instr[RT_LSB +: 3];
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    OC        <= dec_oc;
                    A         <= rs_val;
                    B         <= rt_val;
                    C0        <= c0_val;
                    illegal_q <= dec_illegal;
                    cnt       <= EXEC_LAST;
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        state <= S_WB;
                        if (illegal_q) begin
                            err <= 1'b1;
                        end else begin
                            res_valid <= 1'b1;
                            res_addr  <= rd_q;
                            res_data  <= O;
                            if (wb_ok) rf[rd_q] <= O;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
